// File: rtl/fmac_pkg.sv
// Shared constants and FSM state encoding for the FMAC receive unload path.
package fmac_pkg;

  localparam int WIDTH          = 256;
  localparam int BYTES_PER_WORD = 32;
  localparam int MAX_LEN        = 9600;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

endpackage

// File: rtl/fmac_rx_skid2.sv
// Two-entry skid buffer: head register drives the outputs, tail absorbs one
// extra word so the upstream read pipeline never has to stall mid-flight.
module fmac_rx_skid2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);
  import fmac_pkg::*;

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign pop       = out_valid && out_ready;

  // Pop shifts tail into head; a push lands in the first free slot after the pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_d - 2'd1;
    end
    if (in_valid) begin
      if (cnt_d == 2'd0) begin
        head_d = in_data;
      end else begin
        tail_d = in_data;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fmac_rx_unload.sv
// Unloads received frames from the RX data/length FIFO pair into a
// sop/eop/byte-enable stream, dropping empty and oversized frames.
module fmac_rx_unload #(
  parameter int WIDTH   = fmac_pkg::WIDTH,
  parameter int LEN_W   = 14,
  parameter int MAX_LEN = fmac_pkg::MAX_LEN
) (
  input  logic               rdclk,
  input  logic               aclr,
  output logic               rdreq,
  input  logic [WIDTH-1:0]   q,
  input  logic               rdempty,
  output logic               ctl_rdreq,
  input  logic [LEN_W-1:0]   ctl_q,
  input  logic               ctl_rdempty,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic [WIDTH/8-1:0] out_be,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);
  import fmac_pkg::*;

  localparam int BEW   = WIDTH / 8;
  localparam int REM_W = $clog2(BYTES_PER_WORD);
  localparam int PW    = WIDTH + 2 + BEW;

  logic [2:0]       state_q, state_d;
  logic             run_q, run_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             first_q, first_d;
  logic             pend_q, pend_d;
  logic             pend_sop_q, pend_sop_d;
  logic             pend_eop_q, pend_eop_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [PW-1:0]    sk_in_data, sk_out_data;
  logic [1:0]       sk_count;
  logic             sk_pop;
  logic [2:0]       occ_next;
  logic [REM_W-1:0] rem;
  logic [BEW-1:0]   eop_be, pend_be;

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign sk_pop    = out_valid && out_ready;

  // Byte enables for the word arriving from the FIFO this cycle.
  always_comb begin
    rem     = len_q[REM_W-1:0];
    eop_be  = (rem == '0) ? '1 : ((BEW'(1) << rem) - BEW'(1));
    pend_be = pend_eop_q ? eop_be : '1;
  end

  assign sk_in_data = {q, pend_sop_q, pend_eop_q, pend_be};
  assign {out_data, out_sop, out_eop, out_be} = sk_out_data;

  fmac_rx_skid2 #(
    .DW(PW)
  ) u_skid (
    .clk      (rdclk),
    .rst      (aclr),
    .in_valid (pend_q),
    .in_data  (sk_in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (sk_out_data),
    .count    (sk_count)
  );

  // Occupancy is counted after this cycle's departing beat, so a word can be
  // read every cycle while the consumer keeps pace and never more than two
  // words sit between the FIFO output and the stream.
  assign occ_next = {1'b0, sk_count} - {2'b0, sk_pop} + {2'b0, pend_q};

  // Frame sequencing FSM, FIFO pops and counters.
  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    len_d       = len_q;
    words_d     = words_q;
    first_d     = first_q;
    pend_d      = 1'b0;
    pend_sop_d  = pend_sop_q;
    pend_eop_d  = pend_eop_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    rdreq       = 1'b0;
    ctl_rdreq   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q && !ctl_rdempty && sk_count == 2'd0 && !pend_q) begin
          ctl_rdreq = 1'b1;
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        len_d   = ctl_q;
        words_d = (ctl_q >> REM_W) + {{(LEN_W-1){1'b0}}, |ctl_q[REM_W-1:0]};
        state_d = S_CHK;
      end
      S_CHK: begin
        first_d = 1'b1;
        if (len_q == '0) begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = S_IDLE;
        end else if (32'(len_q) > 32'(MAX_LEN)) begin
          state_d = S_DROP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!rdempty && words_q != '0 && occ_next < 3'd2) begin
          rdreq      = 1'b1;
          words_d    = words_q - 1'b1;
          first_d    = 1'b0;
          pend_d     = 1'b1;
          pend_sop_d = first_q;
          pend_eop_d = (words_q == LEN_W'(1));
        end
        if (sk_pop && out_eop) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          state_d     = S_IDLE;
        end
      end
      S_DROP: begin
        if (words_q == '0) begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = S_IDLE;
        end else if (!rdempty) begin
          rdreq   = 1'b1;
          words_d = words_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      len_q       <= '0;
      words_q     <= '0;
      first_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_sop_q  <= 1'b0;
      pend_eop_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      len_q       <= len_d;
      words_q     <= words_d;
      first_q     <= first_d;
      pend_q      <= pend_d;
      pend_sop_q  <= pend_sop_d;
      pend_eop_q  <= pend_eop_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: doc/fmac_rx_unload.md
FMAC_RX_UNLOAD -- requirements
Module: fmac_rx_unload

Interface
REQ-001 SHALL have parameter WIDTH, default 256, data word width in bits.
REQ-002 SHALL have parameter LEN_W, default 14, frame byte-length field width.
REQ-003 SHALL have parameter MAX_LEN, default 9600, largest deliverable frame in bytes.
REQ-004 SHALL have port rdclk, input, 1, the single clock for all logic.
REQ-005 SHALL have port aclr, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port rdreq, output, 1, pop request to the RX data FIFO.
REQ-007 SHALL have port q, input, WIDTH, RX data FIFO output, valid one cycle after rdreq.
REQ-008 SHALL have port rdempty, input, 1, RX data FIFO empty.
REQ-009 SHALL have port ctl_rdreq, output, 1, pop request to the length FIFO.
REQ-010 SHALL have port ctl_q, input, LEN_W, frame byte length, valid one cycle after ctl_rdreq.
REQ-011 SHALL have port ctl_rdempty, input, 1, length FIFO empty.
REQ-012 SHALL have the output stream ports: out_data (WIDTH), out_valid (1), out_ready (input, 1), out_sop (1), out_eop (1), out_be (WIDTH/8, byte enables).
REQ-013 SHALL have port frame_cnt, output, 32, count of delivered frames.
REQ-014 SHALL have port drop_cnt, output, 16, count of dropped frames.

Function
REQ-015 SHALL run the FSM IDLE -> LEN -> CHK -> DATA or DROP -> IDLE.
REQ-016 In IDLE, with ctl_rdempty=0, SHALL assert ctl_rdreq for one cycle and go to LEN.
REQ-017 In LEN, SHALL capture ctl_q and set words = ceil(len/32), computed in LEN_W bits, then go to CHK.
REQ-018 In CHK, len=0 SHALL increment drop_cnt and return to IDLE without popping the data FIFO.
REQ-019 In CHK, len>MAX_LEN SHALL go to DROP; otherwise SHALL go to DATA.
REQ-020 Upstream writes all data words of a frame before its length entry; rdempty=1 in DATA/DROP SHALL only stall, never abort.
REQ-021 In DATA, rdreq SHALL assert only when rdempty=0, words remaining >0, and skid occupancy plus in-flight reads <2.
REQ-022 Each q word SHALL enter a 2-entry skid buffer; out_data/out_sop/out_eop/out_be SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 A beat SHALL transfer when out_valid=1 and out_ready=1; a new beat MAY present in the same cycle, giving full throughput of 1 word/cycle.
REQ-024 out_sop SHALL be 1 on the first word only; out_eop SHALL be 1 on the last word only; a 1-word frame SHALL have both set.
REQ-025 out_be SHALL be all ones except on the eop word, where it SHALL be the low (len mod 32) bits set, or all ones if the remainder is 0.
REQ-026 DATA SHALL exit to IDLE when the eop beat transfers; frame_cnt SHALL increment in that cycle.
REQ-027 DROP SHALL pop words on consecutive non-empty cycles, present nothing, increment drop_cnt after the last pop, then return to IDLE.
REQ-028 frame_cnt SHALL wrap at 2^32; drop_cnt SHALL saturate at 16'hFFFF.
REQ-029 The next frame's IDLE->LEN SHALL NOT start until the skid buffer is empty, so frames never interleave.

Reset
REQ-030 aclr SHALL, asynchronously, set the FSM to IDLE; rdreq, ctl_rdreq, out_valid, out_sop, out_eop=0; out_data=0; out_be=0; counters=0; skid buffer empty.
REQ-031 aclr mid-frame SHALL discard the partial frame with no eop emitted; the FIFOs share the same aclr.

Structure
REQ-032 A shared package fmac_pkg SHALL hold the WIDTH, BYTES_PER_WORD=32 and MAX_LEN constants and the FSM state encoding.
REQ-033 The 2-entry skid buffer SHALL be a sub-module fmac_rx_skid2.

Verification
REQ-034 len=64, out_ready=1 -> 2 beats, sop on beat 1, eop on beat 2, be=32'hFFFFFFFF on both, frame_cnt=1.
REQ-035 len=65 -> 3 beats, last be=32'h00000001; len=1 -> 1 beat with sop=eop=1 and be=32'h1.
REQ-036 len=9601, followed by len=64 -> 301 words popped and nothing presented, drop_cnt=1; then the 64-byte frame is delivered intact.
REQ-037 len=0 -> no rdreq, drop_cnt=1, next frame unaffected.
REQ-038 len=320 with out_ready toggling 1/0 each cycle -> 10 beats, data stable during stalls, no loss or duplication, at most 2 reads outstanding.
REQ-039 aclr pulsed after beat 3 of 10 -> all outputs 0 immediately; a fresh frame after reset is delivered correctly.
